// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one async-read IMEM between fetch (F, priority) and debug (D) ports
// Ports: clk/rst (async, active-high); f_valid/f_addr/f_ready and d_valid/d_addr/d_ready request
// handshakes; f_rsp_* and d_rsp_* registered responses one cycle after grant;
// imem_addr/imem_inst drive and read the shared memory.
module imem_port_arbiter #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  input  logic [31:0]       f_addr,
  output logic              f_ready,
  output logic              f_rsp_valid,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_valid,
  input  logic [31:0]       d_addr,
  output logic              d_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst
);
  localparam logic [3:0]  MW    = 4'(MAX_WAIT);
  localparam logic [31:0] LIMIT = 32'(4 << ADDR_W);
  logic [3:0]  wait_cnt;
  logic        d_grant, f_grant, err;
  logic [31:0] addr, off;
  assign d_grant   = d_valid & (~f_valid | (wait_cnt == MW));
  assign f_grant   = f_valid & ~d_grant;
  assign f_ready   = f_grant;
  assign d_ready   = d_grant;
  assign addr      = d_grant ? d_addr : f_addr;
  // addresses below the base wrap to huge offsets and fail the range check
  assign off       = addr - BASE_ADDR;
  assign err       = (addr[1:0] != 2'b00) | (off >= LIMIT);
  assign imem_addr = (f_grant | d_grant) ? off[ADDR_W+1:2] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt    <= '0;
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      f_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else begin
      wait_cnt    <= (d_valid & ~d_grant) ? ((wait_cnt == MW) ? MW : wait_cnt + 4'd1) : 4'd0;
      f_rsp_valid <= f_grant;
      d_rsp_valid <= d_grant;
      if (f_grant) begin
        f_rsp_err  <= err;
        f_rsp_data <= err ? 32'h0 : imem_inst;
      end
      if (d_grant) begin
        d_rsp_err  <= err;
        d_rsp_data <= err ? 32'h0 : imem_inst;
      end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;
  localparam int          ADDR_W   = 11;
  localparam int          MAX_WAIT = 4;
  localparam logic [31:0] BASE     = 32'h00400000;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              f_valid = 1'b0, d_valid = 1'b0;
  logic [31:0]       f_addr = '0, d_addr = '0;
  logic              f_ready, d_ready;
  logic              f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err;
  logic [31:0]       f_rsp_data, d_rsp_data, imem_inst;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       mem [2**ADDR_W];
  int                n_checks = 0, n_fail = 0;
  imem_port_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .imem_addr(imem_addr), .imem_inst(imem_inst)
  );
  assign imem_inst = mem[imem_addr];
  always #5 clk = ~clk;
  function automatic logic [31:0] memval(int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: legality is a plain interval test on the byte address
  function automatic bit addr_ok(logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (a % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * (2 ** ADDR_W));
  endfunction
  function automatic logic [ADDR_W-1:0] word_of(logic [31:0] a);
    return ADDR_W'((a - BASE) / 4);
  endfunction
  logic        m_fv, m_fe, m_dv, m_de, nx_fv, nx_fe, nx_dv, nx_de;
  logic [31:0] m_fd, m_dd, nx_fd, nx_dd, ga;
  int          m_stall, nx_stall;
  bit          dg, fg;
  always @(negedge clk) begin
    dg = d_valid && (!f_valid || m_stall == MAX_WAIT);
    fg = f_valid && !dg;
    ga = dg ? d_addr : f_addr;
    if (!rst) begin
      check("f_ready", 32'(f_ready), 32'(fg));
      check("d_ready", 32'(d_ready), 32'(dg));
      check("imem_addr", 32'(imem_addr), (fg || dg) ? 32'(word_of(ga)) : 32'h0);
      check("f_rsp_valid", 32'(f_rsp_valid), 32'(m_fv));
      check("f_rsp_err", 32'(f_rsp_err), 32'(m_fe));
      check("f_rsp_data", f_rsp_data, m_fd);
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(m_dv));
      check("d_rsp_err", 32'(d_rsp_err), 32'(m_de));
      check("d_rsp_data", d_rsp_data, m_dd);
    end
    nx_fv    = fg;
    nx_dv    = dg;
    nx_fe    = fg ? !addr_ok(ga) : m_fe;
    nx_fd    = fg ? (addr_ok(ga) ? memval(int'(word_of(ga))) : 32'h0) : m_fd;
    nx_de    = dg ? !addr_ok(ga) : m_de;
    nx_dd    = dg ? (addr_ok(ga) ? memval(int'(word_of(ga))) : 32'h0) : m_dd;
    nx_stall = (d_valid && !dg) ? ((m_stall + 1 > MAX_WAIT) ? MAX_WAIT : m_stall + 1) : 0;
  end
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_fv <= 1'b0; m_fe <= 1'b0; m_fd <= '0;
      m_dv <= 1'b0; m_de <= 1'b0; m_dd <= '0;
      m_stall <= 0;
    end else begin
      m_fv <= nx_fv; m_fe <= nx_fe; m_fd <= nx_fd;
      m_dv <= nx_dv; m_de <= nx_de; m_dd <= nx_dd;
      m_stall <= nx_stall;
    end
  // single request on one port; returns at the negedge where the response is visible
  task automatic do_req(input bit dport, input logic [31:0] a, output logic rdy,
                        output logic [ADDR_W-1:0] ia, output logic rv,
                        output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    if (dport) begin d_valid = 1'b1; d_addr = a; end
    else begin f_valid = 1'b1; f_addr = a; end
    @(negedge clk);
    rdy = dport ? d_ready : f_ready;
    ia  = imem_addr;
    @(posedge clk); #1;
    d_valid = 1'b0;
    f_valid = 1'b0;
    @(negedge clk);
    rv   = dport ? d_rsp_valid : f_rsp_valid;
    data = dport ? d_rsp_data : f_rsp_data;
    err  = dport ? d_rsp_err : f_rsp_err;
  endtask
  // holds F busy and D requesting for n cycles, returns bitmap of cycles D was granted
  task automatic contend(input int n, output logic [15:0] pat);
    pat = '0;
    @(posedge clk); #1;
    f_valid = 1'b1; f_addr = BASE + 32'h10;
    d_valid = 1'b1; d_addr = BASE + 32'h20;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pat[k] = d_ready;
      @(posedge clk); #1;
    end
    f_valid = 1'b0;
    d_valid = 1'b0;
  endtask
  logic              rdy, rv, err;
  logic [ADDR_W-1:0] ia;
  logic [31:0]       data;
  logic [15:0]       pat;
  int                dseen;
  initial begin
    for (int i = 0; i < 2 ** ADDR_W; i++) mem[i] = memval(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rsp", {f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err}, 32'h0);
    check("reset data", f_rsp_data | d_rsp_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    // basic fetch
    do_req(1'b0, 32'h00400008, rdy, ia, rv, data, err);
    check("t1 ready", 32'(rdy), 32'h1);
    check("t1 imem_addr", 32'(ia), 32'h2);
    check("t1 rsp", {31'h0, rv}, 32'h1);
    check("t1 data", data, 32'hC0DE0002);
    check("t1 err", 32'(err), 32'h0);
    @(negedge clk);
    check("t1 pulse ends", 32'(f_rsp_valid), 32'h0);
    // 4F:1D pattern
    contend(10, pat);
    check("t2 pattern", 32'(pat), 32'h0210);
    // range boundaries on D
    do_req(1'b1, 32'h00401FFC, rdy, ia, rv, data, err);
    check("t3 last imem_addr", 32'(ia), 32'h7FF);
    check("t3 last data", data, 32'hC0DE07FF);
    check("t3 last err", 32'(err), 32'h0);
    do_req(1'b1, 32'h00402000, rdy, ia, rv, data, err);
    check("t3 past end err", 32'(err), 32'h1);
    check("t3 past end data", data, 32'h0);
    do_req(1'b1, 32'h003FFFFC, rdy, ia, rv, data, err);
    check("t3 below base err", 32'(err), 32'h1);
    check("t3 below base valid", 32'(rv), 32'h1);
    // misaligned fetch
    do_req(1'b0, 32'h00400002, rdy, ia, rv, data, err);
    check("t4 err", 32'(err), 32'h1);
    check("t4 data", data, 32'h0);
    // reset during a grant cycle, with D part-way through a stall
    do_req(1'b0, 32'h00400014, rdy, ia, rv, data, err);
    check("t5 pre data", data, 32'hC0DE0005);
    @(posedge clk); #1;
    f_valid = 1'b1; f_addr = 32'h0040000C;
    d_valid = 1'b1; d_addr = 32'h00400004;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5 rsp valid", {30'h0, f_rsp_valid, d_rsp_valid}, 32'h0);
    check("t5 data", f_rsp_data | d_rsp_data, 32'h0);
    check("t5 err", {30'h0, f_rsp_err, d_rsp_err}, 32'h0);
    f_valid = 1'b0;
    d_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    contend(5, pat);
    check("t5 stall restarts", 32'(pat), 32'h0010);
    do_req(1'b0, 32'h00400008, rdy, ia, rv, data, err);
    check("t5 resume", data, 32'hC0DE0002);
    // D pulsed briefly under F load, then withdrawn
    @(posedge clk); #1;
    f_valid = 1'b1; f_addr = BASE;
    d_valid = 1'b1; d_addr = BASE + 32'h40;
    dseen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dseen += int'(d_ready) + int'(d_rsp_valid);
      @(posedge clk); #1;
      if (k == 1) d_valid = 1'b0;
    end
    f_valid = 1'b0;
    check("t6 no D service", 32'(dseen), 32'h0);
    contend(5, pat);
    check("t6 wait cleared", 32'(pat), 32'h0010);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
